uart_param_core: RTL and testbench

//   Parametrised full-duplex UART core: baud tick generator, TX/RX FIFOs and serialiser/deserialiser.

---
 rtl/uart_param_core.sv | 384 ++++++++++++++++++++++++++++++++++++++
 tb/tb_uart_param_core.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_param_core.sv
// Full-duplex UART core: baud tick, TX/RX FIFOs, serialiser and deserialiser.
// Frame format (parity, stop bits) is selectable at runtime and latched per frame.
module uart_param_core #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 11,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] baud_divisor,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_wr,
  output logic                 tx_full,
  output logic [LW-1:0]        tx_level,
  output logic                 tx_busy,
  output logic                 tx,
  input  logic                 rx,
  input  logic                 rx_rd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_empty,
  output logic [LW-1:0]        rx_level,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  input  logic                 err_clr
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int OSW = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);

  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] OS_HALF = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0]  DB_LAST = BW'(DATA_BITS - 1);
  localparam logic [LW-1:0]  LV_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    T_IDLE, T_START, T_DATA, T_PAR, T_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_WAIT
  } rx_state_t;

  // ---------------- baud tick ----------------
  logic [DIV_WIDTH-1:0] baud_cnt;
  logic [DIV_WIDTH-1:0] div_q;
  logic                 tick;

  assign tick = (baud_cnt == div_q);

  // divisor is only picked up at the wrap so a period is never cut short
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt <= '0;
      div_q    <= '0;
    end else if (tick) begin
      baud_cnt <= '0;
      div_q    <= baud_divisor;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] txf_mem [FIFO_DEPTH];
  logic [AW-1:0]        txf_wp;
  logic [AW-1:0]        txf_rp;
  logic [LW-1:0]        txf_lvl;
  logic                 txf_empty;
  logic                 txf_push;
  logic                 txf_pop;
  logic                 tx_pop;
  logic [DATA_BITS-1:0] txf_head;

  assign txf_empty = (txf_lvl == '0);
  assign tx_full   = (txf_lvl == LV_FULL);
  assign tx_level  = txf_lvl;
  assign txf_head  = txf_mem[txf_rp];
  assign txf_pop   = tx_pop && !txf_empty;
  assign txf_push  = tx_wr && (!tx_full || txf_pop);

  always_ff @(posedge clk) begin
    if (txf_push)
      txf_mem[txf_wp] <= tx_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txf_wp  <= '0;
      txf_rp  <= '0;
      txf_lvl <= '0;
    end else begin
      if (txf_push)
        txf_wp <= txf_wp + 1'b1;
      if (txf_pop)
        txf_rp <= txf_rp + 1'b1;
      if (txf_push && !txf_pop)
        txf_lvl <= txf_lvl + 1'b1;
      else if (!txf_push && txf_pop)
        txf_lvl <= txf_lvl - 1'b1;
    end
  end

  // ---------------- TX serialiser ----------------
  tx_state_t            tx_st, tx_st_d;
  logic [DATA_BITS-1:0] tx_sh, tx_sh_d;
  logic [OSW-1:0]       tx_tc, tx_tc_d;
  logic [BW-1:0]        tx_bit, tx_bit_d;
  logic                 tx_par, tx_par_d;
  logic                 tx_pe, tx_pe_d;
  logic                 tx_two, tx_two_d;
  logic                 tx_s2, tx_s2_d;
  logic                 tx_end;

  assign tx_end = tick && (tx_tc == OS_LAST);

  always_comb begin
    tx_st_d  = tx_st;
    tx_sh_d  = tx_sh;
    tx_tc_d  = tx_tc;
    tx_bit_d = tx_bit;
    tx_par_d = tx_par;
    tx_pe_d  = tx_pe;
    tx_two_d = tx_two;
    tx_s2_d  = tx_s2;
    tx_pop   = 1'b0;
    if (tick && tx_st != T_IDLE)
      tx_tc_d = tx_end ? '0 : tx_tc + 1'b1;
    unique case (tx_st)
      T_IDLE: begin
        if (tick && !txf_empty) begin
          tx_pop   = 1'b1;
          tx_sh_d  = txf_head;
          tx_par_d = ^txf_head ^ parity_odd;
          tx_pe_d  = parity_en;
          tx_two_d = two_stop;
          tx_tc_d  = '0;
          tx_st_d  = T_START;
        end
      end
      T_START: begin
        if (tx_end) begin
          tx_bit_d = '0;
          tx_st_d  = T_DATA;
        end
      end
      T_DATA: begin
        if (tx_end) begin
          tx_sh_d = tx_sh >> 1;
          tx_s2_d = 1'b0;
          if (tx_bit == DB_LAST)
            tx_st_d = tx_pe ? T_PAR : T_STOP;
          else
            tx_bit_d = tx_bit + 1'b1;
        end
      end
      T_PAR: begin
        if (tx_end)
          tx_st_d = T_STOP;
      end
      T_STOP: begin
        if (tx_end) begin
          if (tx_two && !tx_s2)
            tx_s2_d = 1'b1;
          else
            tx_st_d = T_IDLE;
        end
      end
      default: tx_st_d = T_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_st  <= T_IDLE;
      tx_sh  <= '0;
      tx_tc  <= '0;
      tx_bit <= '0;
      tx_par <= 1'b0;
      tx_pe  <= 1'b0;
      tx_two <= 1'b0;
      tx_s2  <= 1'b0;
    end else begin
      tx_st  <= tx_st_d;
      tx_sh  <= tx_sh_d;
      tx_tc  <= tx_tc_d;
      tx_bit <= tx_bit_d;
      tx_par <= tx_par_d;
      tx_pe  <= tx_pe_d;
      tx_two <= tx_two_d;
      tx_s2  <= tx_s2_d;
    end
  end

  always_comb begin
    tx = 1'b1;
    unique case (tx_st)
      T_START: tx = 1'b0;
      T_DATA:  tx = tx_sh[0];
      T_PAR:   tx = tx_par;
      default: tx = 1'b1;
    endcase
  end

  assign tx_busy = (tx_st != T_IDLE);

  // ---------------- RX synchroniser ----------------
  logic rx_m;
  logic rx_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // ---------------- RX deserialiser ----------------
  rx_state_t            rx_st, rx_st_d;
  logic [DATA_BITS-1:0] rx_sh, rx_sh_d;
  logic [OSW-1:0]       rx_tc, rx_tc_d;
  logic [BW-1:0]        rx_bit, rx_bit_d;
  logic                 rx_pe, rx_pe_d;
  logic                 rx_odd, rx_odd_d;
  logic                 rx_pbad, rx_pbad_d;
  logic                 rx_done;
  logic                 rx_sbad;
  logic                 rx_half;
  logic                 rx_samp;

  assign rx_half = tick && (rx_tc == OS_HALF);
  assign rx_samp = tick && (rx_tc == OS_LAST);

  always_comb begin
    rx_st_d   = rx_st;
    rx_sh_d   = rx_sh;
    rx_tc_d   = rx_tc;
    rx_bit_d  = rx_bit;
    rx_pe_d   = rx_pe;
    rx_odd_d  = rx_odd;
    rx_pbad_d = rx_pbad;
    rx_done   = 1'b0;
    rx_sbad   = 1'b0;
    if (tick && rx_st != R_IDLE && rx_st != R_WAIT)
      rx_tc_d = rx_tc + 1'b1;
    unique case (rx_st)
      R_IDLE: begin
        if (tick && !rx_s) begin
          rx_tc_d   = '0;
          rx_pe_d   = parity_en;
          rx_odd_d  = parity_odd;
          rx_pbad_d = 1'b0;
          rx_st_d   = R_START;
        end
      end
      R_START: begin
        if (rx_half) begin
          rx_tc_d  = '0;
          rx_bit_d = '0;
          rx_st_d  = rx_s ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (rx_samp) begin
          rx_tc_d = '0;
          rx_sh_d = {rx_s, rx_sh[DATA_BITS-1:1]};
          if (rx_bit == DB_LAST)
            rx_st_d = rx_pe ? R_PAR : R_STOP;
          else
            rx_bit_d = rx_bit + 1'b1;
        end
      end
      R_PAR: begin
        if (rx_samp) begin
          rx_tc_d   = '0;
          rx_pbad_d = rx_s != (^rx_sh ^ rx_odd);
          rx_st_d   = R_STOP;
        end
      end
      R_STOP: begin
        if (rx_samp) begin
          rx_done = 1'b1;
          rx_sbad = !rx_s;
          rx_st_d = rx_s ? R_IDLE : R_WAIT;
        end
      end
      R_WAIT: begin
        if (rx_s)
          rx_st_d = R_IDLE;
      end
      default: rx_st_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_st   <= R_IDLE;
      rx_sh   <= '0;
      rx_tc   <= '0;
      rx_bit  <= '0;
      rx_pe   <= 1'b0;
      rx_odd  <= 1'b0;
      rx_pbad <= 1'b0;
    end else begin
      rx_st   <= rx_st_d;
      rx_sh   <= rx_sh_d;
      rx_tc   <= rx_tc_d;
      rx_bit  <= rx_bit_d;
      rx_pe   <= rx_pe_d;
      rx_odd  <= rx_odd_d;
      rx_pbad <= rx_pbad_d;
    end
  end

  // ---------------- RX FIFO ----------------
  logic [DATA_BITS-1:0] rxf_mem [FIFO_DEPTH];
  logic [AW-1:0]        rxf_wp;
  logic [AW-1:0]        rxf_rp;
  logic [LW-1:0]        rxf_lvl;
  logic                 rxf_full;
  logic                 rxf_push;
  logic                 rxf_pop;

  assign rx_empty = (rxf_lvl == '0);
  assign rxf_full = (rxf_lvl == LV_FULL);
  assign rx_level = rxf_lvl;
  assign rxf_pop  = rx_rd && !rx_empty;
  assign rxf_push = rx_done && (!rxf_full || rxf_pop);
  assign rx_data  = rx_empty ? '0 : rxf_mem[rxf_rp];

  always_ff @(posedge clk) begin
    if (rxf_push)
      rxf_mem[rxf_wp] <= rx_sh;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxf_wp  <= '0;
      rxf_rp  <= '0;
      rxf_lvl <= '0;
    end else begin
      if (rxf_push)
        rxf_wp <= rxf_wp + 1'b1;
      if (rxf_pop)
        rxf_rp <= rxf_rp + 1'b1;
      if (rxf_push && !rxf_pop)
        rxf_lvl <= rxf_lvl + 1'b1;
      else if (!rxf_push && rxf_pop)
        rxf_lvl <= rxf_lvl - 1'b1;
    end
  end

  // ---------------- sticky errors ----------------
  logic par_set;
  logic frm_set;
  logic ovr_set;

  assign par_set = rx_done && rx_pbad;
  assign frm_set = rx_done && rx_sbad;
  assign ovr_set = rx_done && rxf_full && !rxf_pop;

  // a new event in the same cycle as err_clr keeps the flag set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      parity_err  <= par_set || (parity_err && !err_clr);
      frame_err   <= frm_set || (frame_err && !err_clr);
      overrun_err <= ovr_set || (overrun_err && !err_clr);
    end
  end

endmodule

// File: tb/tb_uart_param_core.sv
// Directed bench for uart_param_core: TX waveform, loopback, error flags,
// glitch rejection, RX overrun and asynchronous reset mid-frame.
module tb_uart_param_core;

  localparam int DB = 8;
  localparam int LW = 5;
  localparam int DW = 11;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] baud_divisor = 11'd3;
  logic          parity_en = 1'b0;
  logic          parity_odd = 1'b0;
  logic          two_stop = 1'b0;
  logic [DB-1:0] tx_data = '0;
  logic          tx_wr = 1'b0;
  logic          tx_full;
  logic [LW-1:0] tx_level;
  logic          tx_busy;
  logic          tx;
  logic          rx_line;
  logic          rx_rd = 1'b0;
  logic [DB-1:0] rx_data;
  logic          rx_empty;
  logic [LW-1:0] rx_level;
  logic          parity_err;
  logic          frame_err;
  logic          overrun_err;
  logic          err_clr = 1'b0;

  logic   loop = 1'b0;
  logic   rx_tb = 1'b1;
  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;

  assign rx_line = loop ? tx : rx_tb;

  uart_param_core dut (
    .clk          (clk),
    .reset        (reset),
    .baud_divisor (baud_divisor),
    .parity_en    (parity_en),
    .parity_odd   (parity_odd),
    .two_stop     (two_stop),
    .tx_data      (tx_data),
    .tx_wr        (tx_wr),
    .tx_full      (tx_full),
    .tx_level     (tx_level),
    .tx_busy      (tx_busy),
    .tx           (tx),
    .rx           (rx_line),
    .rx_rd        (rx_rd),
    .rx_data      (rx_data),
    .rx_empty     (rx_empty),
    .rx_level     (rx_level),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .overrun_err  (overrun_err),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_tx(input logic [7:0] d);
    tx_data = d;
    tx_wr = 1'b1;
    step(1);
    tx_wr = 1'b0;
  endtask

  task automatic pop_rx();
    rx_rd = 1'b1;
    step(1);
    rx_rd = 1'b0;
  endtask

  task automatic wait_fall(input string tag);
    int n;
    n = 0;
    while (tx !== 1'b0 && n < 3000) begin
      step(1);
      n++;
    end
    check(tag, tx, 1'b0);
  endtask

  // samples the middle of each bit, starting with the start bit
  task automatic grab(input string tag, input int nbits,
                      output logic [15:0] bits, output longint t0);
    bits = '0;
    wait_fall(tag);
    t0 = cyc;
    step(32);
    for (int i = 0; i < nbits; i++) begin
      bits[i] = tx;
      if (i < nbits - 1)
        step(64);
    end
  endtask

  task automatic send_rx(input logic [7:0] d, input logic pe,
                         input logic pbit, input logic stopv);
    rx_tb = 1'b0;
    step(64);
    for (int i = 0; i < 8; i++) begin
      rx_tb = d[i];
      step(64);
    end
    if (pe) begin
      rx_tb = pbit;
      step(64);
    end
    rx_tb = stopv;
    step(64);
    rx_tb = 1'b1;
    step(128);
  endtask

  logic [15:0] bits;
  longint      t0, t1, t2;
  int          lowcnt;
  logic [7:0]  exp_b [3];

  initial begin
    exp_b[0] = 8'h3C;
    exp_b[1] = 8'hFF;
    exp_b[2] = 8'h00;

    // reset state
    step(3);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_full", tx_full, 1'b0);
    check("rst_empty", rx_empty, 1'b1);
    check("rst_lvls", {tx_level, rx_level}, 10'd0);
    check("rst_errs", {parity_err, frame_err, overrun_err}, 3'b000);
    check("rst_rxdata", rx_data, 8'h00);
    reset = 1'b0;
    step(5);

    // 1: 8N1 0xA5 waveform
    push_tx(8'hA5);
    wait_fall("t1_fall");
    lowcnt = 0;
    while (tx === 1'b0 && lowcnt < 200) begin
      lowcnt++;
      step(1);
    end
    check("t1_start_len", lowcnt, 64);
    step(32);
    bits = '0;
    for (int i = 0; i < 8; i++) begin
      bits[i] = tx;
      step(64);
    end
    check("t1_data", bits[7:0], 8'hA5);
    check("t1_stop", {tx, tx_busy}, 2'b11);
    step(64);
    check("t1_busy_end", {tx, tx_busy}, 2'b10);

    // 2: loopback, odd parity, two stop bits
    loop = 1'b1;
    parity_en = 1'b1;
    parity_odd = 1'b1;
    two_stop = 1'b1;
    step(2);
    push_tx(8'h3C);
    push_tx(8'hFF);
    push_tx(8'h00);
    for (int f = 0; f < 3; f++) begin
      grab("t2_fall", 12, bits, t0);
      if (f == 1) t1 = t0;
      if (f == 2) t2 = t0;
      check("t2_start", bits[0], 1'b0);
      check("t2_data", bits[8:1], exp_b[f]);
      check("t2_parity", bits[9], 1'b1);
      check("t2_stops", bits[11:10], 2'b11);
    end
    check("t2_gap", 32'(t2 - t1), 32'd772);
    step(100);
    check("t2_level", rx_level, 5'd3);
    check("t2_errs", {parity_err, frame_err, overrun_err}, 3'b000);
    for (int f = 0; f < 3; f++) begin
      check("t2_rxdata", rx_data, exp_b[f]);
      pop_rx();
    end
    check("t2_empty", rx_empty, 1'b1);

    // 3: bad parity then bad stop, then clear
    loop = 1'b0;
    two_stop = 1'b0;
    step(200);
    send_rx(8'h12, 1'b1, 1'b0, 1'b1);
    check("t3_perr", {parity_err, frame_err}, 2'b10);
    send_rx(8'h34, 1'b1, 1'b0, 1'b0);
    check("t3_ferr", {parity_err, frame_err}, 2'b11);
    check("t3_level", rx_level, 5'd2);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    step(1);
    check("t3_clr", {parity_err, frame_err}, 2'b00);
    check("t3_d0", rx_data, 8'h12);
    pop_rx();
    check("t3_d1", rx_data, 8'h34);
    pop_rx();
    check("t3_empty", rx_empty, 1'b1);

    // 5: short low glitch rejected, next frame still fine
    parity_en = 1'b0;
    parity_odd = 1'b0;
    rx_tb = 1'b0;
    step(20);
    rx_tb = 1'b1;
    step(200);
    check("t5_empty", {rx_empty, rx_level}, {1'b1, 5'd0});
    check("t5_ferr", frame_err, 1'b0);
    send_rx(8'h77, 1'b0, 1'b0, 1'b1);
    check("t5_next", rx_data, 8'h77);
    pop_rx();

    // 4: fill RX FIFO, 17th frame overruns
    for (int i = 0; i < 16; i++)
      send_rx(8'h10 + 8'(i), 1'b0, 1'b0, 1'b1);
    check("t4_full_lvl", rx_level, 5'd16);
    check("t4_no_ovr", overrun_err, 1'b0);
    send_rx(8'h5A, 1'b0, 1'b0, 1'b1);
    check("t4_ovr", overrun_err, 1'b1);
    check("t4_lvl", rx_level, 5'd16);
    check("t4_head", rx_data, 8'h10);

    // 6: reset in the middle of a TX and an RX frame
    push_tx(8'h81);
    push_tx(8'h42);
    wait_fall("t6_fall");
    rx_tb = 1'b0;
    step(100);
    check("t6_pre_busy", tx_busy, 1'b1);
    reset = 1'b1;
    #1;
    check("t6_tx", {tx, tx_busy, tx_full}, 3'b100);
    check("t6_lvls", {tx_level, rx_level}, 10'd0);
    check("t6_empty", {rx_empty, rx_data}, {1'b1, 8'h00});
    check("t6_errs", {parity_err, frame_err, overrun_err}, 3'b000);
    step(1);
    rx_tb = 1'b1;
    step(2);
    reset = 1'b0;
    loop = 1'b1;
    step(5);
    push_tx(8'hC3);
    grab("t6_fall2", 10, bits, t0);
    check("t6_frame", bits[9:0], {1'b1, 8'hC3, 1'b0});
    step(100);
    check("t6_rx", {rx_level, rx_data}, {5'd1, 8'hC3});
    check("t6_errs2", {parity_err, frame_err, overrun_err}, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
